// File: rtl/mips_data_mem_if.sv
// rtl/mips_data_mem_if.sv - CPU select/address and loader handshake bundle for mips_data_mem
interface mips_data_mem_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          CS;
  logic          WE;
  logic [AW-1:0] ADDR;
  logic          LD_VALID;
  logic          LD_READY;
  logic [AW-1:0] LD_ADDR;
  logic [DW-1:0] LD_DATA;
  logic [15:0]   RD_CNT;
  logic [15:0]   WR_CNT;
  logic          PERR;

  modport master (
    output CS, WE, ADDR, LD_VALID, LD_ADDR, LD_DATA,
    input  LD_READY, RD_CNT, WR_CNT, PERR
  );

  modport slave (
    input  CS, WE, ADDR, LD_VALID, LD_ADDR, LD_DATA,
    output LD_READY, RD_CNT, WR_CNT, PERR
  );
endinterface

// File: rtl/mips_data_mem.sv
// rtl/mips_data_mem.sv - MIPS data memory with zero-latency bus reads, loader port, access counters; optional MEM_PARITY_EN
module mips_data_mem #(
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int DEPTH = 128
) (
  input  logic            CLK,
  input  logic            RST_N,
  inout  tri   [DW-1:0]   Mem_Bus,
  mips_data_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  state_t        state;
  logic [AW-1:0] last_addr;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;
  logic          rd_en;
  logic          cpu_wr;
  logic          ld_fire;

  // Reads and writes are both gated by reset so nothing moves while RST_N is low.
  assign rd_en   = RST_N & bus.CS & ~bus.WE;
  assign cpu_wr  = RST_N & bus.CS &  bus.WE;
  // Loader only gets the array when the CPU is not selecting it.
  assign bus.LD_READY = ~bus.CS & RST_N;
  assign ld_fire      = bus.LD_VALID & bus.LD_READY;

  // Read data goes straight onto the shared bus in the same cycle; released otherwise.
  assign Mem_Bus = rd_en ? mem[bus.ADDR] : {DW{1'bz}};

  assign bus.RD_CNT = rd_cnt;
  assign bus.WR_CNT = wr_cnt;

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_q;

  // Array and parity update; CPU and loader never collide because LD_READY needs CS low.
  always_ff @(posedge CLK) begin
    if (cpu_wr) begin
      mem[bus.ADDR]     <= Mem_Bus;
      par_mem[bus.ADDR] <= ^Mem_Bus;
    end else if (ld_fire) begin
      mem[bus.LD_ADDR]     <= bus.LD_DATA;
      par_mem[bus.LD_ADDR] <= ^bus.LD_DATA;
    end
  end

  // Sticky error: any CPU read whose word disagrees with its stored even parity.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perr_q <= 1'b0;
    end else if (rd_en && ((^mem[bus.ADDR]) != par_mem[bus.ADDR])) begin
      perr_q <= 1'b1;
    end
  end

  assign bus.PERR = perr_q;
`else
  // Array update; CPU and loader never collide because LD_READY needs CS low.
  always_ff @(posedge CLK) begin
    if (cpu_wr) begin
      mem[bus.ADDR] <= Mem_Bus;
    end else if (ld_fire) begin
      mem[bus.LD_ADDR] <= bus.LD_DATA;
    end
  end

  assign bus.PERR = 1'b0;
`endif

  // Access FSM and saturating counters; a held read on one address counts once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      last_addr <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      last_addr <= bus.ADDR;
      if (!bus.CS) begin
        state <= IDLE;
      end else if (bus.WE) begin
        state <= WR;
        if (wr_cnt != 16'hFFFF) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
      end else begin
        state <= RD;
        if (((state != RD) || (bus.ADDR != last_addr)) && (rd_cnt != 16'hFFFF)) begin
          rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// tb/tb_mips_data_mem.sv - scoreboard bench for mips_data_mem with randomized traffic and directed cases
module tb_mips_data_mem;

  logic        CLK;
  logic        RST_N;
  logic        cpu_drive;
  logic [31:0] cpu_wdata;
  tri   [31:0] Mem_Bus;

  mips_data_mem_if #(.AW(7), .DW(32)) bus ();

  assign Mem_Bus = cpu_drive ? cpu_wdata : 32'bz;
  pullup (Mem_Bus);

  mips_data_mem #(.AW(7), .DW(32), .DEPTH(128)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .Mem_Bus (Mem_Bus),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [128];
  logic [6:0]  valid_q [$];
  logic [15:0] rd_m = 16'd0;
  logic [15:0] wr_m = 16'd0;
  bit          prev_rd = 1'b0;
  logic [6:0]  prev_addr = 7'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] inc_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic bit is_valid(input logic [6:0] a);
    foreach (valid_q[i]) if (valid_q[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: every CPU read cycle out of reset consumes one expected word.
  always @(negedge CLK) begin
    if (RST_N && bus.CS && !bus.WE) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL read_unexpected: got %h expected no read at %0t", Mem_Bus, $time);
      end else begin
        chk("mem_bus_read", Mem_Bus, exp_q.pop_front());
      end
    end
  end

  // One bus cycle, entered at posedge+1; returns at the next posedge+1 with inputs idle.
  task automatic drive(input logic cs, input logic we, input logic [6:0] addr,
                       input logic [31:0] wdata, input logic ldv,
                       input logic [6:0] la, input logic [31:0] ld);
    bus.CS       = cs;
    bus.WE       = we;
    bus.ADDR     = addr;
    cpu_drive    = cs & we;
    cpu_wdata    = wdata;
    bus.LD_VALID = ldv;
    bus.LD_ADDR  = la;
    bus.LD_DATA  = ld;
    if (cs && !we) exp_q.push_back(model_mem[addr]);
    @(negedge CLK);
    chk("ld_ready", {31'd0, bus.LD_READY}, {31'd0, ~cs});
    if (cs && we) begin
      model_mem[addr] = wdata;
      if (!is_valid(addr)) valid_q.push_back(addr);
      wr_m = inc_sat(wr_m);
    end
    if (cs && !we && !(prev_rd && prev_addr == addr)) rd_m = inc_sat(rd_m);
    if (!cs && ldv) begin
      model_mem[la] = ld;
      if (!is_valid(la)) valid_q.push_back(la);
    end
    prev_rd   = cs & ~we;
    prev_addr = addr;
    @(posedge CLK);
    #1;
    bus.CS       = 1'b0;
    bus.WE       = 1'b0;
    cpu_drive    = 1'b0;
    bus.LD_VALID = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic chk_cnt();
    chk("rd_cnt", {16'd0, bus.RD_CNT}, {16'd0, rd_m});
    chk("wr_cnt", {16'd0, bus.WR_CNT}, {16'd0, wr_m});
  endtask

  task automatic model_reset();
    rd_m    = 16'd0;
    wr_m    = 16'd0;
    prev_rd = 1'b0;
  endtask

  logic [31:0] pre [4];

  initial begin
    pre[0] = 32'h20010005; pre[1] = 32'h20020003;
    pre[2] = 32'h00221820; pre[3] = 32'hAC030010;
    RST_N = 1'b0; cpu_drive = 1'b0; cpu_wdata = 32'd0;
    bus.CS = 1'b0; bus.WE = 1'b0; bus.ADDR = 7'd0;
    bus.LD_VALID = 1'b0; bus.LD_ADDR = 7'd0; bus.LD_DATA = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rd_cnt", {16'd0, bus.RD_CNT}, 32'd0);
    chk("reset_wr_cnt", {16'd0, bus.WR_CNT}, 32'd0);
    chk("reset_perr", {31'd0, bus.PERR}, 32'd0);
    chk("reset_ld_ready", {31'd0, bus.LD_READY}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Loader preload then same-cycle CPU reads of each word.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'(i), pre[i]);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 7'(i), 32'd0, 1'b0, 7'd0, 32'd0);
    chk("preload_rd_cnt", {16'd0, bus.RD_CNT}, 32'd4);

    // Write then a two-cycle read hold on the same address.
    drive(1'b1, 1'b1, 7'd16, 32'hDEADBEEF, 1'b0, 7'd0, 32'd0);
    drive(1'b1, 1'b0, 7'd16, 32'd0, 1'b0, 7'd0, 32'd0);
    drive(1'b1, 1'b0, 7'd16, 32'd0, 1'b0, 7'd0, 32'd0);
    chk("wr_rd_wr_cnt", {16'd0, bus.WR_CNT}, 32'd1);
    chk("wr_rd_rd_cnt", {16'd0, bus.RD_CNT}, 32'd5);

    // Loader held off by three CPU cycles, accepted on the first CS=0 edge.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 7'd0, 32'd0, 1'b1, 7'd7, 32'h1234);
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd7, 32'h1234);
    drive(1'b1, 1'b0, 7'd7, 32'd0, 1'b0, 7'd0, 32'd0);
    chk_cnt();

    // Asynchronous reset in the middle of a write to address 5.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd5, 32'hCAFEF00D);
    bus.CS = 1'b1; bus.WE = 1'b1; bus.ADDR = 7'd5;
    cpu_wdata = 32'h0BADBAD0; cpu_drive = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    chk("midrst_rd_cnt", {16'd0, bus.RD_CNT}, 32'd0);
    chk("midrst_wr_cnt", {16'd0, bus.WR_CNT}, 32'd0);
    chk("midrst_perr", {31'd0, bus.PERR}, 32'd0);
    @(posedge CLK);
    #1;
    bus.CS = 1'b0; bus.WE = 1'b0; cpu_drive = 1'b0;
    bus.LD_VALID = 1'b1; bus.LD_ADDR = 7'd6; bus.LD_DATA = 32'h0;
    #1;
    chk("midrst_ld_ready", {31'd0, bus.LD_READY}, 32'd0);
    bus.LD_VALID = 1'b0;
    bus.CS = 1'b1; bus.ADDR = 7'd5;
    #1;
    chk("midrst_bus_hiz", Mem_Bus, 32'hFFFFFFFF);
    bus.CS = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    drive(1'b1, 1'b0, 7'd5, 32'd0, 1'b0, 7'd0, 32'd0);
    chk_cnt();

    // Randomized mix of CPU reads, CPU writes and loader transfers.
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [6:0] a;
      op = $urandom_range(0, 2);
      a  = 7'($urandom_range(0, 127));
      if (op == 0) begin
        drive(1'b0, 1'b0, 7'd0, 32'd0, 1'($urandom_range(0, 1)), a, $urandom);
      end else if (op == 1) begin
        drive(1'b1, 1'b1, a, $urandom, 1'b0, 7'd0, 32'd0);
      end else begin
        a = valid_q[$urandom_range(0, valid_q.size() - 1)];
        if ($urandom_range(0, 3) == 0) a = prev_addr;
        if (!is_valid(a)) a = valid_q[0];
        drive(1'b1, 1'b0, a, 32'd0, 1'b0, 7'd0, 32'd0);
      end
      chk_cnt();
      chk("rand_perr", {31'd0, bus.PERR}, 32'd0);
    end

    // Write counter saturation.
    for (int n = 0; n < 65536; n++) drive(1'b1, 1'b1, 7'(n), 32'(n), 1'b0, 7'd0, 32'd0);
    chk("sat_wr_cnt", {16'd0, bus.WR_CNT}, 32'h0000FFFF);
    drive(1'b1, 1'b1, 7'd3, 32'h3, 1'b0, 7'd0, 32'd0);
    chk("sat_wr_cnt_hold", {16'd0, bus.WR_CNT}, 32'h0000FFFF);

    // Parity error on address 9.
    drive(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd9, 32'h0000_0F0E);
    drive(1'b1, 1'b0, 7'd9, 32'd0, 1'b0, 7'd0, 32'd0);
    chk("perr_clean", {31'd0, bus.PERR}, 32'd0);
`ifdef MEM_PARITY_EN
    dut.par_mem[9] <= ~dut.par_mem[9];
    #1;
    drive(1'b1, 1'b0, 7'd9, 32'd0, 1'b0, 7'd0, 32'd0);
    chk("perr_set", {31'd0, bus.PERR}, 32'd1);
    idle();
    idle();
    chk("perr_sticky", {31'd0, bus.PERR}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("perr_cleared", {31'd0, bus.PERR}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
`else
    drive(1'b1, 1'b0, 7'd9, 32'd0, 1'b0, 7'd0, 32'd0);
    idle();
    chk("perr_tied_low", {31'd0, bus.PERR}, 32'd0);
`endif
    drive(1'b1, 1'b0, 7'd9, 32'd0, 1'b0, 7'd0, 32'd0);
    chk_cnt();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_data_mem.md
MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 The parameter lines SHALL be:
- AW, 7, word address width.
- DW, 32, data width.
- DEPTH, 128, number of words (2**AW).
REQ-002 The port lines SHALL be:
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- CS  input  1  chip select from the CPU.
- WE  input  1  write enable from the CPU; qualified by CS.
- ADDR  input  AW  CPU word address.
- Mem_Bus  inout  DW  shared data bus; the CPU drives it on writes, this block drives it on reads.
- LD_VALID  input  1  loader word valid.
- LD_READY  output  1  loader word accepted this cycle.
- LD_ADDR  input  AW  loader word address.
- LD_DATA  input  DW  loader word data.
- RD_CNT  output  16  count of completed CPU reads.
- WR_CNT  output  16  count of completed CPU writes.
- PERR  output  1  sticky parity-error flag.

Function
REQ-003 Storage SHALL be DEPTH x DW words with no byte enables; the array is not reset.
REQ-004 A CPU read (CS=1, WE=0) SHALL drive Mem_Bus combinationally with mem[ADDR] in the same cycle, so data is valid before the next rising edge (zero-cycle latency).
REQ-005 Mem_Bus SHALL be high-Z whenever CS=0 or WE=1, and during reset.
REQ-006 A CPU write (CS=1, WE=1) SHALL store Mem_Bus into mem[ADDR] at the rising edge; the written data is readable from the next cycle.
REQ-007 A read and a write to the same address in consecutive cycles SHALL return the new data.
REQ-008 The access FSM SHALL have three states, updated every edge:
- IDLE when CS=0.
- RD when CS & !WE.
- WR when CS & WE.
REQ-009 RD_CNT SHALL increment once per entry into RD from any other state.
REQ-010 RD_CNT SHALL increment once per clock of a held RD only when ADDR changes; a two-cycle lw hold on one address counts as one read.
REQ-011 WR_CNT SHALL increment once per cycle in WR.
REQ-012 RD_CNT and WR_CNT SHALL saturate at 16'hFFFF.
REQ-013 The loader SHALL complete a transfer when LD_VALID & LD_READY at the rising edge, writing LD_DATA to mem[LD_ADDR].
REQ-014 LD_READY SHALL be combinational: LD_READY = !CS & RST_N.
REQ-015 The CPU SHALL always have priority; a held LD_VALID SHALL wait with LD_ADDR and LD_DATA stable until accepted.
REQ-016 Loader transfers SHALL NOT change RD_CNT or WR_CNT.
REQ-017 Out-of-range addresses cannot occur because DEPTH = 2**AW; the address SHALL wrap naturally.

Reset
REQ-018 Asserting RST_N=0 SHALL, asynchronously and at any time including mid-access:
- set the FSM to IDLE;
- clear RD_CNT, WR_CNT and PERR to 0;
- force Mem_Bus to high-Z and LD_READY to 0.
REQ-019 Array contents SHALL be unchanged by reset, and no write SHALL occur in any cycle where RST_N=0.
REQ-020 After RST_N deasserts, the first rising edge SHALL behave normally.

Configuration
REQ-021 With MEM_PARITY_EN defined:
- each word SHALL store an even-parity bit, computed on both CPU and loader writes;
- each CPU read cycle SHALL check parity;
- a mismatch SHALL set PERR at the next rising edge, and PERR SHALL hold until reset.
REQ-022 With MEM_PARITY_EN undefined, no parity storage SHALL exist and PERR SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset: RST_N=0 mid-write (CS=1, WE=1, ADDR=5) -> no write to mem[5]; RD_CNT=0, WR_CNT=0, PERR=0; Mem_Bus high-Z; LD_READY=0.
- Loader preload: words 0..3 = 32'h20010005, 32'h20020003, 32'h00221820, 32'hAC030010 loaded with CS=0 -> each accepted in one cycle; CPU reads of ADDR 0..3 return those values same cycle; RD_CNT=4.
- Write then read: CPU sw of 32'hDEADBEEF to ADDR 16, then CS=1, WE=0, ADDR=16 held two cycles -> Mem_Bus=32'hDEADBEEF on both cycles; WR_CNT=1; RD_CNT increments by 1.
- Priority: LD_VALID=1 (ADDR 7, 32'h1234) while CS=1 for 3 cycles -> LD_READY=0 for 3 cycles; the word is written on the first CS=0 edge; the CPU read of 7 then returns 32'h1234.
- Saturation: force 65536 write cycles -> WR_CNT holds at 16'hFFFF.
- MEM_PARITY_EN: corrupt the stored parity of ADDR 9 through a bench backdoor, then CPU read ADDR 9 -> PERR=1 next cycle and stays 1 until RST_N=0; without the macro PERR stays 0.
